// File: rtl/feeder_pkg.sv
// Shared definitions for the operand feeder and the controller/datapath operand map.
package feeder_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int NUM_OPS_DEF = 7;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } issue_state_t;

  // Width needed to index n words; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_slot.sv
// One frame buffer: NUM_OPS words of DATA_W bits, written one word at a time, read as a flat bus.
module operand_slot
  import feeder_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int NUM_OPS = NUM_OPS_DEF,
  localparam int IDX_W   = idx_width(NUM_OPS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_we,
  input  logic [IDX_W-1:0]            i_idx,
  input  logic [DATA_W-1:0]           i_data,
  output logic [NUM_OPS*DATA_W-1:0]   o_words
);

  logic [DATA_W-1:0] r_words [NUM_OPS];

  // Store the incoming word at the selected index; the bank clears on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) r_words[i] <= '0;
    end else if (i_we) begin
      r_words[i_idx] <= i_data;
    end
  end

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_flat
    assign o_words[g*DATA_W +: DATA_W] = r_words[g];
  end

endmodule

// File: rtl/operand_feeder.sv
// Assembles serial operand words into frames, double-buffers them and launches one job per frame.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_in_valid,
  input  logic [DATA_W-1:0]           i_in_data,
  input  logic                        i_in_last,
  output logic                        o_in_ready,
  input  logic                        i_op_ready,
  input  logic                        i_done_next,
  output logic                        o_start,
  output logic [NUM_OPS*DATA_W-1:0]   o_operands,
  output logic                        o_busy,
  output logic                        o_frame_err,
  output logic [CNT_W-1:0]            o_jobs_done
);

  localparam int               IDX_W    = idx_width(NUM_OPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  logic [1:0]       r_full;
  logic             r_wp;
  logic             r_rp;
  logic [IDX_W-1:0] r_cnt;
  issue_state_t     r_state;
  logic             r_start;
  logic             r_busy;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_jobs;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_at_last;
  logic                      w_frame_ok;
  logic                      w_frame_bad;
  logic                      w_done;
  logic [1:0]                w_set;
  logic [1:0]                w_clr;
  logic [NUM_OPS*DATA_W-1:0] w_slot0_words;
  logic [NUM_OPS*DATA_W-1:0] w_slot1_words;

  // The write slot only takes words while it is empty, so a full slot is never overwritten.
  assign w_in_ready  = ~r_full[r_wp];
  assign w_accept    = i_in_valid & w_in_ready;
  assign w_at_last   = (r_cnt == LAST_IDX);
  assign w_frame_ok  = w_accept & w_at_last & i_in_last;
  assign w_frame_bad = w_accept & (w_at_last ^ i_in_last);
  assign w_done      = (r_state == BUSY) & i_done_next;
  assign w_set       = {w_frame_ok & r_wp, w_frame_ok & ~r_wp};
  assign w_clr       = {w_done & r_rp, w_done & ~r_rp};

  operand_slot #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS)) u_slot0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_accept & ~r_wp),
    .i_idx   (r_cnt),
    .i_data  (i_in_data),
    .o_words (w_slot0_words)
  );

  operand_slot #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS)) u_slot1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_accept & r_wp),
    .i_idx   (r_cnt),
    .i_data  (i_in_data),
    .o_words (w_slot1_words)
  );

  // Word counter and write pointer: a good frame moves to the other slot, a malformed one restarts in place.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_wp        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_accept) begin
        if (w_at_last || i_in_last) r_cnt <= '0;
        else                        r_cnt <= r_cnt + 1'b1;
      end
      if (w_frame_ok) r_wp <= ~r_wp;
    end
  end

  // Full flags; a frame landing and a job retiring in the same cycle always hit different slots.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_full <= '0;
    else          r_full <= (r_full & ~w_clr) | w_set;
  end

  // Issue FSM: launch the oldest full frame, hold it until the controller reports completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_rp    <= 1'b0;
      r_jobs  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_full[r_rp] && i_op_ready) begin
            r_state <= LAUNCH;
            r_start <= 1'b1;
          end
        end
        LAUNCH: begin
          r_start <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= BUSY;
        end
        BUSY: begin
          if (w_done) begin
            r_busy  <= 1'b0;
            r_rp    <= ~r_rp;
            r_state <= IDLE;
            if (r_jobs != '1) r_jobs <= r_jobs + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is forced low while reset is held so every output reads zero during reset.
  assign o_in_ready  = i_rst_n & w_in_ready;
  assign o_start     = r_start;
  assign o_busy      = r_busy;
  assign o_frame_err = r_frame_err;
  assign o_jobs_done = r_jobs;
  assign o_operands  = r_rp ? w_slot1_words : w_slot0_words;

endmodule

// File: tb/tb_operand_feeder.sv
// Testbench for operand_feeder: directed scenarios plus a randomized run against a frame-level model.
module tb_operand_feeder;

  localparam int DW   = 8;
  localparam int NOPS = 7;
  localparam int CW   = 16;
  localparam int FW   = DW * NOPS;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          inValid = 1'b0;
  logic [DW-1:0] inData = '0;
  logic          inLast = 1'b0;
  logic          opReady = 1'b0;
  logic          doneNext = 1'b0;
  logic          inReady;
  logic          start;
  logic [FW-1:0] operands;
  logic          busy;
  logic          frameErr;
  logic [CW-1:0] jobsDone;

  int nCompared = 0;
  int nMismatched = 0;

  // Frame-level reference: words of the frame being assembled, queued complete frames (front is the
  // one being executed), and the expected issue/busy/error/counter outputs for the current cycle.
  logic [DW-1:0] mPartial[$];
  logic [FW-1:0] mFrames[$];
  bit            mStart;
  bit            mBusy;
  bit            mErr;
  int            mJobs;
  logic [FW-1:0] expStarts[$];

  // Operand bus captured at every observed start pulse, and a running count of error pulses.
  logic [FW-1:0] startLog[$];
  int            errCount = 0;

  operand_feeder #(.DATA_W(DW), .NUM_OPS(NOPS), .CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid),
    .i_in_data   (inData),
    .i_in_last   (inLast),
    .o_in_ready  (inReady),
    .i_op_ready  (opReady),
    .i_done_next (doneNext),
    .o_start     (start),
    .o_operands  (operands),
    .o_busy      (busy),
    .o_frame_err (frameErr),
    .o_jobs_done (jobsDone)
  );

  always #5 clk = ~clk;

  // Record what the DUT launched, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstN) begin
      if (start) startLog.push_back(operands);
      if (frameErr) errCount++;
    end
  end

  // Return the reference to its power-on state.
  task automatic modelReset();
    mPartial.delete();
    mFrames.delete();
    mStart = 0;
    mBusy  = 0;
    mErr   = 0;
    mJobs  = 0;
  endtask

  // Advance one clock, applying the frame rules to the inputs presented before the edge.
  task automatic tick();
    bit readyPre, accept, doneHit, launchNow, nextBusy;
    int pos;
    logic [FW-1:0] f;
    @(posedge clk);
    if (rstN) begin
      readyPre  = (mFrames.size() < 2);
      accept    = inValid && readyPre;
      doneHit   = mBusy && doneNext;
      launchNow = !mStart && !mBusy && (mFrames.size() > 0) && opReady;
      nextBusy  = mStart || (mBusy && !doneHit);
      if (launchNow) expStarts.push_back(mFrames[0]);
      mStart = launchNow;
      mBusy  = nextBusy;
      if (doneHit) begin
        void'(mFrames.pop_front());
        if (mJobs < (1 << CW) - 1) mJobs++;
      end
      mErr = 0;
      if (accept) begin
        pos = mPartial.size();
        mPartial.push_back(inData);
        if (inLast && pos == NOPS - 1) begin
          f = '0;
          for (int i = 0; i < NOPS; i++) f[i*DW +: DW] = mPartial[i];
          mFrames.push_back(f);
          mPartial.delete();
        end else if (inLast || pos == NOPS - 1) begin
          mErr = 1;
          mPartial.delete();
        end
      end
    end
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic sendWord(input logic [DW-1:0] d, input logic l, output bit ok);
    bit acc;
    acc = 0;
    inValid = 1'b1;
    inData  = d;
    inLast  = l;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = inReady;
      tick();
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    ok = acc;
  endtask

  // Send a whole well-formed frame, word 0 first.
  task automatic sendFrame(input logic [FW-1:0] f, output bit ok);
    bit w;
    ok = 1;
    for (int i = 0; i < NOPS; i++) begin
      sendWord(f[i*DW +: DW], (i == NOPS - 1), w);
      ok &= w;
    end
  endtask

  function automatic logic [FW-1:0] randFrame();
    logic [FW-1:0] f;
    for (int i = 0; i < NOPS; i++) f[i*DW +: DW] = DW'($urandom_range(0, 255));
    return f;
  endfunction

  // Step until n starts have been recorded (bounded).
  task automatic waitStarts(input int n, output bit ok);
    for (int k = 0; k < 40 && startLog.size() < n; k++) tick();
    ok = (startLog.size() >= n);
  endtask

  // Step until the job is in flight (bounded).
  task automatic waitBusy(output bit ok);
    for (int k = 0; k < 40 && !busy; k++) tick();
    ok = busy;
  endtask

  // One-cycle completion pulse from the controller.
  task automatic pulseDone();
    doneNext = 1'b1;
    tick();
    doneNext = 1'b0;
  endtask

  // Hold reset for two cycles and release it away from the clock edge.
  task automatic applyReset();
    rstN = 1'b0;
    inValid = 0; inLast = 0; doneNext = 0; opReady = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    #1;
  endtask

  // Outputs during and right after power-on reset.
  task automatic test_reset();
    modelReset();
    #2;
    nCompared++; if (start !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_start: got %b expected 0", start); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    nCompared++; if (inReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_in_ready: got %b expected 0", inReady); end
    nCompared++; if (frameErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_frame_err: got %b expected 0", frameErr); end
    nCompared++; if (jobsDone !== '0) begin nMismatched++; $display("[TB] FAIL rst_jobs: got %0d expected 0", jobsDone); end
    nCompared++; if (operands !== '0) begin nMismatched++; $display("[TB] FAIL rst_operands: got %h expected 0", operands); end
    @(posedge clk);
    #3 rstN = 1'b1;
    #1;
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL rel_in_ready: got %b expected 1", inReady); end
  endtask

  // Words 1..7: start two cycles after the last word, bus ordered word 0 in the low byte.
  task automatic test_single_frame();
    logic [FW-1:0] f;
    bit ok;
    f = 56'h07060504030201;
    opReady = 1'b1;
    sendFrame(f, ok);
    nCompared++; if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL t1_accept: got %b expected 1", ok); end
    nCompared++; if (start !== 1'b0) begin nMismatched++; $display("[TB] FAIL t1_start_early: got %b expected 0", start); end
    tick();
    nCompared++; if (start !== 1'b1) begin nMismatched++; $display("[TB] FAIL t1_start_t2: got %b expected 1", start); end
    nCompared++; if (operands !== f) begin nMismatched++; $display("[TB] FAIL t1_operands: got %h expected %h", operands, f); end
    tick();
    nCompared++; if (start !== 1'b0) begin nMismatched++; $display("[TB] FAIL t1_start_width: got %b expected 0", start); end
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL t1_busy: got %b expected 1", busy); end
    repeat (3) tick();
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL t1_busy_hold: got %b expected 1", busy); end
    nCompared++; if (operands !== f) begin nMismatched++; $display("[TB] FAIL t1_operands_hold: got %h expected %h", operands, f); end
    pulseDone();
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL t1_busy_after: got %b expected 0", busy); end
    nCompared++; if (jobsDone !== 16'd1) begin nMismatched++; $display("[TB] FAIL t1_jobs: got %0d expected 1", jobsDone); end
  endtask

  // Three frames while job 1 runs: the third stalls until a slot frees, starts stay in order.
  task automatic test_back_to_back();
    logic [FW-1:0] a, b, c;
    int s0, j0;
    bit ok;
    a = randFrame(); b = randFrame(); c = randFrame();
    s0 = startLog.size();
    j0 = mJobs;
    opReady = 1'b1;
    sendFrame(a, ok);
    waitStarts(s0 + 1, ok);
    nCompared++; if (!ok || startLog[s0] !== a) begin nMismatched++; $display("[TB] FAIL t2_start1: got %h expected %h", ok ? startLog[s0] : '0, a); end
    waitBusy(ok);
    nCompared++; if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL t2_busy1: got %b expected 1", ok); end
    sendFrame(b, ok);
    nCompared++; if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL t2_accept2: got %b expected 1", ok); end
    inValid = 1'b1; inData = c[DW-1:0]; inLast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nCompared++; if (inReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL t2_stall%0d: got %b expected 0", k, inReady); end
      tick();
    end
    doneNext = 1'b1;
    tick();
    doneNext = 1'b0;
    inValid = 1'b0;
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL t2_ready_after_done: got %b expected 1", inReady); end
    sendFrame(c, ok);
    nCompared++; if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL t2_accept3: got %b expected 1", ok); end
    waitStarts(s0 + 2, ok);
    nCompared++; if (!ok || startLog[s0+1] !== b) begin nMismatched++; $display("[TB] FAIL t2_start2: got %h expected %h", ok ? startLog[s0+1] : '0, b); end
    waitBusy(ok);
    pulseDone();
    waitStarts(s0 + 3, ok);
    nCompared++; if (!ok || startLog[s0+2] !== c) begin nMismatched++; $display("[TB] FAIL t2_start3: got %h expected %h", ok ? startLog[s0+2] : '0, c); end
    waitBusy(ok);
    pulseDone();
    nCompared++; if (jobsDone !== CW'(j0 + 3)) begin nMismatched++; $display("[TB] FAIL t2_jobs: got %0d expected %0d", jobsDone, j0 + 3); end
  endtask

  // in_last on word 4: one error pulse, no launch, then a normal frame still lines up.
  task automatic test_early_last();
    logic [FW-1:0] f;
    int s0, e0;
    bit ok;
    s0 = startLog.size();
    e0 = errCount;
    opReady = 1'b1;
    for (int i = 0; i < 4; i++) sendWord(DW'($urandom_range(0, 255)), (i == 3), ok);
    nCompared++; if (frameErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL t3_err: got %b expected 1", frameErr); end
    tick();
    nCompared++; if (frameErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL t3_err_width: got %b expected 0", frameErr); end
    repeat (4) tick();
    nCompared++; if (startLog.size() !== s0) begin nMismatched++; $display("[TB] FAIL t3_no_start: got %0d expected %0d", startLog.size(), s0); end
    nCompared++; if (errCount - e0 !== 1) begin nMismatched++; $display("[TB] FAIL t3_err_count: got %0d expected 1", errCount - e0); end
    f = randFrame();
    sendFrame(f, ok);
    waitStarts(s0 + 1, ok);
    nCompared++; if (!ok || startLog[s0] !== f) begin nMismatched++; $display("[TB] FAIL t3_next_frame: got %h expected %h", ok ? startLog[s0] : '0, f); end
    waitBusy(ok);
    pulseDone();
  endtask

  // Seven words without in_last behind a parked good frame: error, slot state untouched.
  task automatic test_missing_last();
    logic [FW-1:0] g;
    int s0;
    bit ok;
    s0 = startLog.size();
    opReady = 1'b0;
    g = randFrame();
    sendFrame(g, ok);
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL t4_ready_one_full: got %b expected 1", inReady); end
    for (int i = 0; i < NOPS; i++) sendWord(DW'($urandom_range(0, 255)), 1'b0, ok);
    nCompared++; if (frameErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL t4_err: got %b expected 1", frameErr); end
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL t4_ready_after_err: got %b expected 1", inReady); end
    opReady = 1'b1;
    waitStarts(s0 + 1, ok);
    nCompared++; if (!ok || startLog[s0] !== g) begin nMismatched++; $display("[TB] FAIL t4_good_frame: got %h expected %h", ok ? startLog[s0] : '0, g); end
    waitBusy(ok);
    pulseDone();
    repeat (5) tick();
    nCompared++; if (startLog.size() !== s0 + 1) begin nMismatched++; $display("[TB] FAIL t4_no_extra_start: got %0d expected %0d", startLog.size(), s0 + 1); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL t4_idle: got %b expected 0", busy); end
  endtask

  // Last word of frame 2 lands in the same cycle as done_next for frame 1.
  task automatic test_collision();
    logic [FW-1:0] f1, f2;
    int s0, j0;
    bit ok;
    s0 = startLog.size();
    j0 = mJobs;
    opReady = 1'b1;
    f1 = randFrame(); f2 = randFrame();
    sendFrame(f1, ok);
    waitBusy(ok);
    for (int i = 0; i < NOPS - 1; i++) sendWord(f2[i*DW +: DW], 1'b0, ok);
    doneNext = 1'b1;
    sendWord(f2[(NOPS-1)*DW +: DW], 1'b1, ok);
    doneNext = 1'b0;
    nCompared++; if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL t5_last_accept: got %b expected 1", ok); end
    nCompared++; if (jobsDone !== CW'(j0 + 1)) begin nMismatched++; $display("[TB] FAIL t5_jobs: got %0d expected %0d", jobsDone, j0 + 1); end
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL t5_ready: got %b expected 1", inReady); end
    waitStarts(s0 + 2, ok);
    nCompared++; if (!ok || startLog[s0+1] !== f2) begin nMismatched++; $display("[TB] FAIL t5_start2: got %h expected %h", ok ? startLog[s0+1] : '0, f2); end
    waitBusy(ok);
    pulseDone();
    nCompared++; if (jobsDone !== CW'(j0 + 2)) begin nMismatched++; $display("[TB] FAIL t5_jobs_end: got %0d expected %0d", jobsDone, j0 + 2); end
  endtask

  // Reset mid-job with a partial fill: everything clears, a stale done_next is ignored.
  task automatic test_reset_mid_job();
    logic [FW-1:0] f1, f3;
    int s0;
    bit ok;
    opReady = 1'b1;
    f1 = randFrame(); f3 = randFrame();
    sendFrame(f1, ok);
    waitBusy(ok);
    for (int i = 0; i < 3; i++) sendWord(DW'($urandom_range(0, 255)), 1'b0, ok);
    s0 = startLog.size();
    #3 rstN = 1'b0;
    modelReset();
    #1;
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL t6_busy: got %b expected 0", busy); end
    nCompared++; if (inReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL t6_in_ready: got %b expected 0", inReady); end
    nCompared++; if (jobsDone !== '0) begin nMismatched++; $display("[TB] FAIL t6_jobs: got %0d expected 0", jobsDone); end
    nCompared++; if (operands !== '0) begin nMismatched++; $display("[TB] FAIL t6_operands: got %h expected 0", operands); end
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    #1;
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL t6_ready_release: got %b expected 1", inReady); end
    pulseDone();
    repeat (3) tick();
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL t6_stale_busy: got %b expected 0", busy); end
    nCompared++; if (jobsDone !== '0) begin nMismatched++; $display("[TB] FAIL t6_stale_jobs: got %0d expected 0", jobsDone); end
    nCompared++; if (startLog.size() !== s0) begin nMismatched++; $display("[TB] FAIL t6_no_start: got %0d expected %0d", startLog.size(), s0); end
    sendFrame(f3, ok);
    waitStarts(s0 + 1, ok);
    nCompared++; if (!ok || startLog[s0] !== f3) begin nMismatched++; $display("[TB] FAIL t6_fresh_frame: got %h expected %h", ok ? startLog[s0] : '0, f3); end
    waitBusy(ok);
    pulseDone();
    nCompared++; if (jobsDone !== 16'd1) begin nMismatched++; $display("[TB] FAIL t6_jobs_end: got %0d expected 1", jobsDone); end
  endtask

  // Random valid/last/op_ready/done_next traffic, including malformed frames and stray done pulses.
  task automatic applyStimulus();
    int pos;
    pos = mPartial.size();
    inValid  = ($urandom_range(0, 9) < 7);
    inData   = DW'($urandom_range(0, 255));
    inLast   = (pos == NOPS - 1);
    if ($urandom_range(0, 15) == 0) inLast = ~inLast;
    opReady  = ($urandom_range(0, 3) != 0);
    doneNext = ($urandom_range(0, 4) == 0);
  endtask

  task automatic test_random();
    int sB, eB, nS, nE;
    applyReset();
    sB = startLog.size();
    eB = expStarts.size();
    for (int c = 0; c < 600; c++) begin
      applyStimulus();
      tick();
      nCompared++; if (start !== mStart) begin nMismatched++; $display("[TB] FAIL rnd_start c%0d: got %b expected %b", c, start, mStart); end
      nCompared++; if (busy !== mBusy) begin nMismatched++; $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", c, busy, mBusy); end
      nCompared++; if (inReady !== (mFrames.size() < 2)) begin nMismatched++; $display("[TB] FAIL rnd_in_ready c%0d: got %b expected %b", c, inReady, mFrames.size() < 2); end
      nCompared++; if (frameErr !== mErr) begin nMismatched++; $display("[TB] FAIL rnd_frame_err c%0d: got %b expected %b", c, frameErr, mErr); end
      nCompared++; if (jobsDone !== CW'(mJobs)) begin nMismatched++; $display("[TB] FAIL rnd_jobs c%0d: got %0d expected %0d", c, jobsDone, mJobs); end
      if ((mStart || mBusy) && mFrames.size() > 0) begin
        nCompared++; if (operands !== mFrames[0]) begin nMismatched++; $display("[TB] FAIL rnd_operands c%0d: got %h expected %h", c, operands, mFrames[0]); end
      end
    end
    inValid = 0; doneNext = 0; opReady = 0;
    #5;
    nS = startLog.size() - sB;
    nE = expStarts.size() - eB;
    nCompared++; if (nS !== nE) begin nMismatched++; $display("[TB] FAIL rnd_start_count: got %0d expected %0d", nS, nE); end
    for (int i = 0; i < nS && i < nE; i++) begin
      nCompared++; if (startLog[sB+i] !== expStarts[eB+i]) begin nMismatched++; $display("[TB] FAIL rnd_start_frame%0d: got %h expected %h", i, startLog[sB+i], expStarts[eB+i]); end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    $display("[TB] operand_feeder bench starting");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_collision();
    test_reset_mid_job();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
